// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: programmable clock divider producing a registered divided
// clock (clk_div) and a last-cycle-of-period strobe (tick). The divide ratio
// can be changed at run time via a load/ack handshake; a new ratio only ever
// takes effect on a period boundary (or immediately while idle), so clk_div
// never produces a runt phase.
module clk_strobe_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             load,
  output logic             load_ack,
  output logic             clk_div,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // Ratios below 2 cannot form a high and a low phase; treat them as 2.
  localparam int               DEF_INT   = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEF_INT);

  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
    if (r < DIV_W'(2)) begin
      clamp_ratio = DIV_W'(2);
    end else begin
      clamp_ratio = r;
    end
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
  logic             pending_q, pending_d;
  logic             load_ack_q, load_ack_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             wrap_s;

  // Next-state logic: FSM, counter, ratio handshake and the next output values.
  // Outputs are derived from the next counter/ratio so the registered outputs
  // line up with the counter value held in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ratio_d      = ratio_q;
    pend_ratio_d = pend_ratio_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    wrap_s       = (cnt_q == (ratio_q - DIV_W'(1)));

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // No period in flight: a new ratio can be adopted right away.
        if (load) begin
          ratio_d    = clamp_ratio(div_ratio);
          pending_d  = 1'b0;
          load_ack_d = 1'b1;
        end else if (pending_q) begin
          ratio_d    = pend_ratio_q;
          pending_d  = 1'b0;
          load_ack_d = 1'b1;
        end else begin
          load_ack_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (wrap_s) begin
          cnt_d = '0;
          // Only a request already pending before this cycle is applied here;
          // a load arriving in the wrap cycle waits for the next boundary.
          if (pending_q) begin
            ratio_d    = pend_ratio_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
          end else begin
            load_ack_d = 1'b0;
          end
          if (enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STOPPING;
          end
        end
        // Last request before the boundary wins.
        if (load) begin
          pending_d    = 1'b1;
          pend_ratio_d = clamp_ratio(div_ratio);
        end else begin
          pend_ratio_d = pend_ratio_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d != ST_IDLE);
    clk_div_d = running_d && (cnt_d < (ratio_d >> 1));
    tick_d    = running_d && (cnt_d == (ratio_d - DIV_W'(1)));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ratio_q      <= DEF_RATIO;
      pend_ratio_q <= DEF_RATIO;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      clk_div_q    <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ratio_q      <= ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      clk_div_q    <= clk_div_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
    end
  end

  assign load_ack = load_ack_q;
  assign clk_div  = clk_div_q;
  assign tick     = tick_q;
  assign running  = running_q;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed self-checking bench for clk_strobe_gen (DIV_W=8, DEFAULT_DIV=4).
// Each step drives inputs, clocks once and compares {clk_div,tick,load_ack,
// running} one time unit after the rising edge against a hand-computed value.
module tb_clk_strobe_gen;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] div_ratio;
  logic       load;
  logic       load_ack;
  logic       clk_div;
  logic       tick;
  logic       running;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       ld;
    logic [7:0] dr;
    logic [3:0] exp;   // {clk_div, tick, load_ack, running}
  } vec_t;

  vec_t vecs[$];

  clk_strobe_gen #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .div_ratio (div_ratio),
    .load      (load),
    .load_ack  (load_ack),
    .clk_div   (clk_div),
    .tick      (tick),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic en, input logic ld,
                      input logic [7:0] dr, input logic [3:0] exp,
                      input string name);
    logic [3:0] act;
    rst_n     = r;
    enable    = en;
    load      = ld;
    div_ratio = dr;
    @(posedge clk);
    #1;
    act   = {clk_div, tick, load_ack, running};
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got {clk_div,tick,ack,run}=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; div_ratio = 8'd0;

    // Default ratio 4, then load 5 at cnt=0, then load 0 in a wrap cycle.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 4'b0000}); // reset
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001}); // cnt0
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001}); // cnt1
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001}); // cnt2
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // cnt3 tick
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001}); // cnt0
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'd5, 4'b1001}); // load 5 -> cnt1
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001}); // cnt2
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // cnt3 tick (still 4)
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1011}); // ratio 5, ack
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001}); // cnt1
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001}); // cnt2
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001}); // cnt3
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // cnt4 tick
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // cnt4 tick
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'd0, 4'b1001}); // load 0 in wrap: no ack yet
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // cnt4 tick (still 5)
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1011}); // ratio 2, ack
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101}); // toggle every cycle
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 4'b0101});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].ld, vecs[i].dr, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Load 6 at cnt=1 with ratio 4: boundary kept, ack with first 6-period.
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, "t3_rst");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t3_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t3_c1");
    step(1'b1, 1'b1, 1'b1, 8'd6, 4'b0001, "t3_ld6_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t3_c3_tick");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1011, "t3_ack_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t3_r6_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t3_r6_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t3_r6_c3");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t3_r6_c4");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t3_r6_c5_tick");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t3_r6_c0");

    // Reset mid-period with a pending load: no ack, default ratio back.
    step(1'b1, 1'b1, 1'b1, 8'd3, 4'b1001, "t6_ld3_c1");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0000, "t6_rst");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t6_c0_noack");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t6_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t6_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t6_c3_tick");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t6_c0_noack2");

    // Drop enable at cnt=1: finish period, then idle; re-raise during stopping.
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t4_c1");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "t4_stop_c2");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0101, "t4_stop_c3_tick");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, "t4_idle");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, "t4_idle2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t4_run_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t4_run_c1");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "t4_stopping_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t4_resume_c3");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t4_resume_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t4_resume_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t4_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t4_c3_tick");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, "t4_stop_at_wrap");

    // Load in IDLE acks next cycle; two loads before wrap give one ack.
    step(1'b1, 1'b0, 1'b1, 8'd8, 4'b0010, "t5_idle_ack");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t5_r8_c0");
    step(1'b1, 1'b1, 1'b1, 8'd3, 4'b1001, "t5_ld3_c1");
    step(1'b1, 1'b1, 1'b1, 8'd7, 4'b1001, "t5_ld7_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t5_c3");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_c4");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_c5");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_c6");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t5_c7_tick");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1011, "t5_r7_ack");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t5_r7_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t5_r7_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_r7_c3");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_r7_c4");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t5_r7_c5");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t5_r7_c6_tick");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t5_r7_c0_noack");

    // Stop, then load ratio 1 in IDLE: behaves as 2.
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b1001, "t2_stop_c1");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b1001, "t2_stop_c2");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "t2_stop_c3");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "t2_stop_c4");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "t2_stop_c5");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0101, "t2_stop_c6_tick");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, "t2_idle");
    step(1'b1, 1'b0, 1'b1, 8'd1, 4'b0010, "t2_ld1_ack");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t2_r2_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t2_r2_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t2_r2_c0b");

    // Stop and load together in RUN: stop wins, ratio applied entering IDLE.
    step(1'b1, 1'b0, 1'b1, 8'd5, 4'b0101, "t7_stop_ld5_c1");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0010, "t7_idle_ack");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t7_r5_c0");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b1001, "t7_r5_c1");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t7_r5_c2");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "t7_r5_c3");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0101, "t7_r5_c4_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
